chroma_key_ctrl: RTL and testbench

Nios-facing control block for the chroma-key pixel datapath. Holds the Avalon-MM-visible staging copy of the video/image enables and the green threshold, and commits them to the datapath only at a frame boundary, so no frame is keyed with mixed settings. Also counts keyed pixels per frame and frames since reset, for software-side threshold tuning. Sits between the Nios system interconnect and the chroma-key combiner, in the 27 MHz video clock domain.

---
 rtl/chroma_pkg.sv | 20 ++
 rtl/chroma_key_ctrl_frame_sync_det.sv | 22 ++
 rtl/chroma_key_ctrl.sv | 118 +++++++++++
 tb/tb_chroma_key_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/chroma_pkg.sv
// chroma_pkg: shared constants and types for the chroma-key control block
package chroma_pkg;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_THG    = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;
   localparam logic [1:0] ADDR_KEYCNT = 2'd3;

   localparam int CTRL_VIDEO  = 0;
   localparam int CTRL_IMAGE  = 1;
   localparam int CTRL_COMMIT = 2;

   localparam logic [9:0] THG_RST_DEFAULT = 10'd512;

   typedef enum logic {
      ST_IDLE,
      ST_PENDING
   } commit_state_t;

endpackage

// File: rtl/chroma_key_ctrl_frame_sync_det.sv
// frame_sync_det: registered start-of-frame pulse on the falling edge of active-low vsync
module frame_sync_det (
   input  logic clk,
   input  logic rst_n,
   input  logic vs,
   output logic sof
);

   logic vs_q;

   // previous vsync starts high so a low vsync out of reset counts as a frame start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_q <= 1'b1;
         sof  <= 1'b0;
      end else begin
         vs_q <= vs;
         sof  <= ~vs & vs_q;
      end
   end

endmodule

// File: rtl/chroma_key_ctrl.sv
// chroma_key_ctrl: staged keying settings committed at frame start, plus keyed-pixel and frame counters
module chroma_key_ctrl
   import chroma_pkg::*;
#(
   parameter int         CNT_W   = 20,
   parameter int         FRM_W   = 16,
   parameter logic [9:0] THG_RST = THG_RST_DEFAULT
) (
   input  logic        iCLK27,
   input  logic        iRST_N,
   input  logic [1:0]  iAddress,
   input  logic        iWrite,
   input  logic [31:0] iWriteData,
   input  logic        iRead,
   output logic [31:0] oReadData,
   input  logic        iVS,
   input  logic        iDVAL,
   input  logic        iKeyHit,
   output logic        oVideoEnable,
   output logic        oImageEnable,
   output logic [9:0]  oThG
);

   commit_state_t    state, state_nxt;
   logic             sof;
   logic             stg_video, stg_image;
   logic [9:0]       stg_thg;
   logic [CNT_W-1:0] run_cnt, key_cnt;
   logic [FRM_W-1:0] frm_cnt;
   logic             wr_ctrl, wr_thg, commit_wr, pending, apply, hit;
   logic [31:0]      rd_val;

   assign wr_ctrl   = iWrite && iAddress == ADDR_CTRL;
   assign wr_thg    = iWrite && iAddress == ADDR_THG;
   assign commit_wr = wr_ctrl && iWriteData[CTRL_COMMIT];
   assign pending   = state == ST_PENDING;
   assign hit       = iDVAL & iKeyHit;

   frame_sync_det u_sync (
      .clk   (iCLK27),
      .rst_n (iRST_N),
      .vs    (iVS),
      .sof   (sof)
   );

   // commit state register
   always_ff @(posedge iCLK27 or negedge iRST_N) begin
      if (!iRST_N) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   // a commit applies only when already pending at frame start; a same-cycle COMMIT re-arms for the next frame
   always_comb begin
      apply     = pending & sof;
      state_nxt = commit_wr ? ST_PENDING : (apply ? ST_IDLE : state);
   end

   // software-visible staging copy
   always_ff @(posedge iCLK27 or negedge iRST_N) begin
      if (!iRST_N) begin
         stg_video <= 1'b0;
         stg_image <= 1'b0;
         stg_thg   <= THG_RST;
      end else begin
         if (wr_ctrl) begin
            stg_video <= iWriteData[CTRL_VIDEO];
            stg_image <= iWriteData[CTRL_IMAGE];
         end
         if (wr_thg) stg_thg <= iWriteData[9:0];
      end
   end

   // committed settings take the pre-write staging values on the apply cycle
   always_ff @(posedge iCLK27 or negedge iRST_N) begin
      if (!iRST_N) begin
         oVideoEnable <= 1'b0;
         oImageEnable <= 1'b0;
         oThG         <= THG_RST;
      end else if (apply) begin
         oVideoEnable <= stg_video;
         oImageEnable <= stg_image;
         oThG         <= stg_thg;
      end
   end

   // saturating keyed-pixel count per frame, latched at frame start; wrapping frame count
   always_ff @(posedge iCLK27 or negedge iRST_N) begin
      if (!iRST_N) begin
         run_cnt <= '0;
         key_cnt <= '0;
         frm_cnt <= '0;
      end else if (sof) begin
         key_cnt <= run_cnt;
         run_cnt <= CNT_W'(hit);
         frm_cnt <= frm_cnt + FRM_W'(1);
      end else if (hit && !(&run_cnt)) begin
         run_cnt <= run_cnt + CNT_W'(1);
      end
   end

   // register read mux
   always_comb begin
      rd_val = 32'd0;
      case (iAddress)
         ADDR_CTRL:   rd_val = {29'd0, pending, stg_image, stg_video};
         ADDR_THG:    rd_val = {22'd0, stg_thg};
         ADDR_STATUS: rd_val = {16'(frm_cnt), 15'd0, pending};
         ADDR_KEYCNT: rd_val = 32'(key_cnt);
      endcase
   end

   // one-cycle read latency; data holds until the next read
   always_ff @(posedge iCLK27 or negedge iRST_N) begin
      if (!iRST_N)    oReadData <= 32'd0;
      else if (iRead) oReadData <= rd_val;
   end

endmodule

// File: tb/tb_chroma_key_ctrl.sv
// tb_chroma_key_ctrl: vector table, corner sequences and randomized check against a frame-level model
module tb_chroma_key_ctrl;
   import chroma_pkg::*;

   localparam int CW = 10;
   localparam int FW = 6;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [1:0]  addr = 2'd0;
   logic        wr = 1'b0, rd = 1'b0;
   logic [31:0] wdata = 32'd0, rdata;
   logic        vs = 1'b1, dval = 1'b0, key = 1'b0;
   logic        vid, img;
   logic [9:0]  thg;

   int n_tests = 0, n_fail = 0;

   always #5 clk = ~clk;

   chroma_key_ctrl #(.CNT_W(CW), .FRM_W(FW)) dut (
      .iCLK27       (clk),
      .iRST_N       (rst_n),
      .iAddress     (addr),
      .iWrite       (wr),
      .iWriteData   (wdata),
      .iRead        (rd),
      .oReadData    (rdata),
      .iVS          (vs),
      .iDVAL        (dval),
      .iKeyHit      (key),
      .oVideoEnable (vid),
      .oImageEnable (img),
      .oThG         (thg)
   );

   // reference model state
   bit          mv, mi, sv, si, mpend, mvsp, msof;
   int          mthg, sthg, mrun, mkey, mfrm;
   logic [31:0] mrd;

   function automatic logic [31:0] regval(input logic [1:0] a);
      case (a)
         2'd0:    return {29'd0, mpend, si, sv};
         2'd1:    return 32'(sthg);
         2'd2:    return {16'(mfrm), 15'd0, mpend};
         default: return 32'(mkey);
      endcase
   endfunction

   task automatic m_reset();
      mv = 0; mi = 0; mthg = 512; sv = 0; si = 0; sthg = 512;
      mpend = 0; mvsp = 1; msof = 0; mrun = 0; mkey = 0; mfrm = 0; mrd = 0;
   endtask

   task automatic m_edge();
      bit cw, h;
      cw = wr && addr == 2'd0 && wdata[2];
      h  = dval && key;
      if (rd) mrd = regval(addr);
      if (msof && mpend) begin
         mv = sv; mi = si; mthg = sthg; mpend = cw;
      end else if (cw) mpend = 1;
      if (wr && addr == 2'd0) begin sv = wdata[0]; si = wdata[1]; end
      if (wr && addr == 2'd1) sthg = int'(wdata[9:0]);
      if (msof) begin
         mkey = mrun; mrun = h; mfrm = (mfrm + 1) % (1 << FW);
      end else if (h && mrun < (1 << CW) - 1) mrun++;
      msof = !vs && mvsp;
      mvsp = vs;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_out(input string nm, input logic [31:0] ev, input logic [31:0] ei, input logic [31:0] et);
      chk({nm, "_video"}, 32'(vid), ev);
      chk({nm, "_image"}, 32'(img), ei);
      chk({nm, "_thg"}, 32'(thg), et);
   endtask

   task automatic cyc();
      @(posedge clk);
      if (rst_n) m_edge(); else m_reset();
      #1;
   endtask

   task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
      addr = a; wdata = d; wr = 1; rd = 0;
      cyc();
      wr = 0;
   endtask

   task automatic rd_reg(input string nm, input logic [1:0] a, input logic [31:0] exp);
      addr = a; rd = 1; wr = 0;
      cyc();
      rd = 0;
      chk(nm, rdata, exp);
   endtask

   task automatic frame_pulse();
      vs = 0; cyc();
      vs = 1; cyc();
      cyc();
   endtask

   typedef struct {
      bit          w;
      logic [1:0]  a;
      logic [31:0] d;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[10];
   int   fc;

   initial begin
      vecs[0] = '{0, 2'd0, 32'd0, 32'd0};
      vecs[1] = '{0, 2'd1, 32'd0, 32'd512};
      vecs[2] = '{0, 2'd2, 32'd0, 32'd0};
      vecs[3] = '{0, 2'd3, 32'd0, 32'd0};
      vecs[4] = '{1, 2'd1, 32'd300, 32'd300};
      vecs[5] = '{1, 2'd1, 32'hFFFF_F3FF, 32'h3FF};
      vecs[6] = '{1, 2'd2, 32'hFFFF_FFFF, 32'd0};
      vecs[7] = '{1, 2'd3, 32'h0000_FFFF, 32'd0};
      vecs[8] = '{1, 2'd0, 32'h3, 32'h3};
      vecs[9] = '{1, 2'd0, 32'h0, 32'h0};

      m_reset();
      #2 rst_n = 0;
      #1 chk_out("reset", 0, 0, 512);
      chk("reset_rdata", rdata, 0);
      cyc(); cyc();
      rst_n = 1;
      cyc();

      // register map vectors
      foreach (vecs[i]) begin
         if (vecs[i].w) wr_reg(vecs[i].a, vecs[i].d);
         rd_reg($sformatf("vec%0d", i), vecs[i].a, vecs[i].exp);
      end
      chk_out("after_vecs", 0, 0, 512);

      // basic commit with 2-cycle latency from the vsync fall
      wr_reg(2'd1, 32'd300);
      wr_reg(2'd0, 32'h7);
      rd_reg("ctrl_pending", 2'd0, 32'h7);
      vs = 0; cyc();
      chk_out("commit_pre", 0, 0, 512);
      vs = 1; cyc();
      chk_out("commit_post", 1, 1, 300);
      rd_reg("ctrl_cleared", 2'd0, 32'h3);

      // read colliding with a write returns the old value
      addr = 2'd1; wdata = 32'd77; wr = 1; rd = 1; cyc(); wr = 0; rd = 0;
      chk("rd_wr_old", rdata, 32'd300);
      rd_reg("rd_wr_new", 2'd1, 32'd77);

      // COMMIT on the sof cycle from IDLE defers to the next frame
      wr_reg(2'd1, 32'd100);
      wr_reg(2'd0, 32'h0);
      vs = 0; cyc();
      addr = 2'd0; wdata = 32'h4; wr = 1; vs = 1; cyc(); wr = 0;
      chk_out("sof_idle_hold", 1, 1, 300);
      rd_reg("sof_idle_pend", 2'd0, 32'h4);
      frame_pulse();
      chk_out("sof_idle_apply", 0, 0, 100);

      // COMMIT on the sof cycle while pending applies old staging and re-arms
      wr_reg(2'd1, 32'd200);
      wr_reg(2'd0, 32'h5);
      vs = 0; cyc();
      addr = 2'd0; wdata = 32'h6; wr = 1; vs = 1; cyc(); wr = 0;
      chk_out("sof_pend_first", 1, 0, 200);
      rd_reg("sof_pend_rearm", 2'd0, 32'h6);
      frame_pulse();
      chk_out("sof_pend_second", 0, 1, 200);

      // keyed-pixel count and frame increment
      frame_pulse();
      fc = mfrm;
      for (int i = 0; i < 1000; i++) begin
         dval = 1; key = (i % 4 == 0); cyc();
      end
      dval = 0; key = 0;
      frame_pulse();
      rd_reg("keycnt_250", 2'd3, 32'd250);
      rd_reg("frame_inc", 2'd2, {16'((fc + 1) % (1 << FW)), 16'd0});

      // saturation
      dval = 1; key = 1;
      for (int i = 0; i < 1100; i++) cyc();
      dval = 0; key = 0;
      frame_pulse();
      rd_reg("keycnt_sat", 2'd3, (32'd1 << CW) - 32'd1);

      // frame counter wrap
      fc = mfrm;
      for (int i = 0; i < (1 << FW); i++) frame_pulse();
      rd_reg("frame_wrap", 2'd2, {16'(fc), 16'd0});

      // asynchronous reset with pending set, no commit afterwards
      wr_reg(2'd1, 32'd55);
      wr_reg(2'd0, 32'h7);
      rd_reg("pre_reset_ctrl", 2'd0, 32'h7);
      #2 rst_n = 0;
      #1 chk_out("async_reset", 0, 0, 512);
      chk("async_reset_rdata", rdata, 0);
      m_reset();
      cyc(); cyc();
      rst_n = 1;
      frame_pulse();
      frame_pulse();
      chk_out("no_commit_after_reset", 0, 0, 512);
      rd_reg("ctrl_after_reset", 2'd0, 32'h0);
      rd_reg("thg_after_reset", 2'd1, 32'd512);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         addr  = 2'($urandom_range(0, 3));
         wr    = ($urandom % 4 == 0);
         rd    = ($urandom % 2 == 0);
         wdata = $urandom;
         vs    = ($urandom % 12 != 0);
         dval  = ($urandom % 4 != 0);
         key   = ($urandom % 2 == 0);
         cyc();
         chk_out("rand", 32'(mv), 32'(mi), 32'(mthg));
         chk("rand_rdata", rdata, mrd);
      end
      wr = 0; rd = 0; vs = 1; dval = 0; key = 0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
